onchip_mem_arbiter: RTL and testbench
=====================================

# onchip_mem_arbiter

Two-port Avalon-MM arbiter that shares the single-port 128-bit on-chip memory (32768 words, 15-bit word address, 16 byte lanes, one-cycle read latency) between two requesters: port 0 (PCIe DMA side) and port 1 (soft-processor/control side). It sits between both masters and the memory's s1 slave. It issues at most one memory access per cycle, uses round-robin arbitration with a bounded hold burst, and steers each read result back to the port that issued the read.

## Interface
- HOLD_MAX, 4: maximum consecutive grants to one port while the other port is requesting (1..15).
- clk  in  1  single clock for all logic and the memory.
- reset  in  1  asynchronous, active-high reset.
- pN_address  in  15  word address, for N = 0, 1.
- pN_byteenable  in  16  byte lanes for writes; ignored for reads.
- pN_read, pN_write  in  1  request strobes; both high in the same cycle is illegal.
- pN_writedata  in  128  write data.
- pN_waitrequest  out  1  high when the port is requesting and not granted this cycle.
- pN_readdata  out  128  read data; valid only when pN_readdatavalid is high.
- pN_readdatavalid  out  1  one-cycle pulse per completed read.
- mem_address  out  15; mem_byteenable  out  16; mem_writedata  out  128  muxed from the granted port.
- mem_chipselect  out  1  high on any granted access.
- mem_write  out  1  high on a granted write.
- mem_clken  out  1  constant 1.
- mem_readdata  in  128  memory q; valid the cycle after the read is issued.

## Operation
- reqN = pN_read | pN_write.
- Registered state:
  - state, one of IDLE, OWN0, OWN1.
  - last, the last port served.
  - hold, a 4-bit counter.
  - rd_pend and rd_port, which track the read in flight.
- Grant is combinational from the registered state and the current requests:
  - No requests: no grant.
  - Exactly one port requesting: that port is granted.
  - Both requesting in IDLE: the port != last is granted.
  - Both requesting in OWNk:
    - If hold < HOLD_MAX-1, port k is granted.
    - Otherwise the other port is granted.
- Update on a grant to port g:
  - If state == OWNg, hold increments; otherwise hold = 0.
  - state = OWNg; last = g.
- On a cycle with no grant: state = IDLE, hold = 0, last unchanged.
- Memory-side outputs when nothing is granted:
  - mem_chipselect and mem_write are 0.
  - The mem_address, mem_byteenable and mem_writedata muxes select port 0 (don't-care values).
- Granted read: rd_pend = 1 and rd_port = g are registered. In the next cycle:
  - p{rd_port}_readdata = mem_readdata.
  - p{rd_port}_readdatavalid = 1.
- pN_readdata is driven from mem_readdata for both ports; only readdatavalid is steered.
- Reads are pipelined: a new read (from either port) can be granted in the same cycle an earlier read's data returns.
- Granted write: completes in the grant cycle. No response is generated.
- Read-during-write to the same address across ports: the returned data is undefined (the memory is configured DONT_CARE). The bench must not check it.
- Reset asserted mid-transaction:
  - Any in-flight read is dropped; no readdatavalid is produced.
  - State clears immediately, regardless of the clock.

## Timing
- Reset values:
  - state = IDLE, last = 1 (so port 0 wins the first tie), hold = 0, rd_pend = 0.
  - pN_readdatavalid = 0.
  - pN_waitrequest = reqN. It is combinational; a port requesting during reset sees waitrequest = 1, because no grant is given while reset is high.
  - mem_chipselect = 0, mem_write = 0.
- Read latency: address accepted at edge T (waitrequest low in the cycle before T); readdatavalid is high in the cycle following edge T.
- Throughput: one access per cycle total.
- Worst-case wait for a continuously requesting port: HOLD_MAX cycles.
- A waitrequest-stalled master must hold its address, data and strobes stable until waitrequest goes low. The arbiter does not latch requests.
- No combinational path from mem_readdata to any memory-side output.

## Test plan
- Reset, then port 0 writes 0xA5.. (all 16 lanes) to address 0x0010, then reads 0x0010:
  - waitrequest stays 0 throughout.
  - p0_readdatavalid pulses exactly 1 cycle after the read is accepted, with data 0xA5..
  - p1_readdatavalid stays 0.
- Both ports issue back-to-back reads continuously (HOLD_MAX = 4), starting in IDLE after reset:
  - Grant sequence is 0,0,0,0,1,1,1,1,0...
  - Each readdatavalid pulse goes to the port that issued the corresponding read, in issue order.
- Port 0 writes with byteenable 0x0001 to a word preloaded with all 0xFF; port 1 then reads that word:
  - Port 1 sees byte 0 = new data and bytes 1..15 = 0xFF.
- Single requester with the other port idle:
  - 100 consecutive reads complete with no waitrequest.
  - hold saturates without blocking the requester.
- Assert reset asynchronously the cycle after a granted read:
  - No readdatavalid appears.
  - After reset release, the first tie is won by port 0.

Source files
------------

// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between the two Avalon-MM requesters, the arbiter and the memory s1 slave.
// Handshake: an access is accepted at the rising edge that ends a cycle in which the port requests and waitrequest is low.
interface onchip_mem_arbiter_if;
  logic [14:0]  p0_address;
  logic [15:0]  p0_byteenable;
  logic         p0_read;
  logic         p0_write;
  logic [127:0] p0_writedata;
  logic         p0_waitrequest;
  logic [127:0] p0_readdata;
  logic         p0_readdatavalid;

  logic [14:0]  p1_address;
  logic [15:0]  p1_byteenable;
  logic         p1_read;
  logic         p1_write;
  logic [127:0] p1_writedata;
  logic         p1_waitrequest;
  logic [127:0] p1_readdata;
  logic         p1_readdatavalid;

  logic [14:0]  mem_address;
  logic [15:0]  mem_byteenable;
  logic [127:0] mem_writedata;
  logic         mem_chipselect;
  logic         mem_write;
  logic         mem_clken;
  logic [127:0] mem_readdata;

  modport slave (
    input  p0_address, p0_byteenable, p0_read, p0_write, p0_writedata,
    output p0_waitrequest, p0_readdata, p0_readdatavalid,
    input  p1_address, p1_byteenable, p1_read, p1_write, p1_writedata,
    output p1_waitrequest, p1_readdata, p1_readdatavalid,
    output mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
    input  mem_readdata
  );

  modport master (
    output p0_address, p0_byteenable, p0_read, p0_write, p0_writedata,
    input  p0_waitrequest, p0_readdata, p0_readdatavalid,
    output p1_address, p1_byteenable, p1_read, p1_write, p1_writedata,
    input  p1_waitrequest, p1_readdata, p1_readdatavalid,
    input  mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip memory between two Avalon-MM masters,
// with a bounded ownership burst and read-return steering back to the issuing port.
module onchip_mem_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  onchip_mem_arbiter_if.slave  bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_port_q, rd_port_d;

  logic req0, req1;
  logic gnt_valid;
  logic gnt_port;
  logic gnt_read;
  state_e own_st;

  assign req0 = bus.p0_read | bus.p0_write;
  assign req1 = bus.p1_read | bus.p1_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      hold_q    <= 4'd0;
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  // Grant is withheld while reset is high so waitrequest mirrors the request.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        gnt_valid = 1'b1;
        case (state_q)
          IDLE:    gnt_port = ~last_q;
          OWN0:    gnt_port = (hold_q < HOLD_LIM) ? 1'b0 : 1'b1;
          OWN1:    gnt_port = (hold_q < HOLD_LIM) ? 1'b1 : 1'b0;
          default: gnt_port = 1'b0;
        endcase
      end else if (req0) begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b0;
      end else if (req1) begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b1;
      end
    end
  end

  assign gnt_read = gnt_valid & (gnt_port ? bus.p1_read : bus.p0_read);
  assign own_st   = gnt_port ? OWN1 : OWN0;

  always_comb begin
    state_d   = IDLE;
    hold_d    = 4'd0;
    last_d    = last_q;
    rd_pend_d = gnt_read;
    rd_port_d = gnt_valid ? gnt_port : rd_port_q;
    if (gnt_valid) begin
      state_d = own_st;
      last_d  = gnt_port;
      // Saturate so a lone requester streaming forever never wraps the counter.
      if (state_q == own_st) begin
        hold_d = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;
      end
    end
  end

  assign bus.p0_waitrequest = req0 & ~(gnt_valid & ~gnt_port);
  assign bus.p1_waitrequest = req1 & ~(gnt_valid &  gnt_port);

  assign bus.p0_readdata      = bus.mem_readdata;
  assign bus.p1_readdata      = bus.mem_readdata;
  assign bus.p0_readdatavalid = rd_pend_q & ~rd_port_q;
  assign bus.p1_readdatavalid = rd_pend_q &  rd_port_q;

  assign bus.mem_address    = (gnt_valid && gnt_port) ? bus.p1_address    : bus.p0_address;
  assign bus.mem_byteenable = (gnt_valid && gnt_port) ? bus.p1_byteenable : bus.p0_byteenable;
  assign bus.mem_writedata  = (gnt_valid && gnt_port) ? bus.p1_writedata  : bus.p0_writedata;
  assign bus.mem_chipselect = gnt_valid;
  assign bus.mem_write      = gnt_valid & (gnt_port ? bus.p1_write : bus.p0_write);
  assign bus.mem_clken      = 1'b1;

  assign state_o = state_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: behavioural 128-bit memory, per-port drivers and a read scoreboard.
module tb_onchip_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  onchip_mem_arbiter_if bus ();

  onchip_mem_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (dbg_state)
  );

  logic [127:0] mem_m [0:32767];
  logic [127:0] ref_m [0:32767];
  logic [128:0] exp_q [$];
  int           gnt_log [$];
  bit           log_en = 1'b0;
  int           errors = 0;
  int           checks = 0;

  // Memory model: registered q, one-cycle latency, byte-lane writes.
  always @(posedge clk) begin
    bus.mem_readdata <= mem_m[bus.mem_address];
    if (bus.mem_chipselect && bus.mem_write) begin
      for (int i = 0; i < 16; i++) begin
        if (bus.mem_byteenable[i]) mem_m[bus.mem_address][8*i +: 8] <= bus.mem_writedata[8*i +: 8];
      end
    end
  end

  // Read-return monitor.
  always @(negedge clk) begin
    logic [128:0] e;
    logic         p;
    if (bus.p0_readdatavalid && bus.p1_readdatavalid) begin
      checks++;
      errors++;
      $display("FAIL rdv_both: both readdatavalid high, required at most one");
    end else if (bus.p0_readdatavalid || bus.p1_readdatavalid) begin
      p = bus.p1_readdatavalid;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdv_unexpected: port %0d readdatavalid with no read outstanding", p);
      end else begin
        e = exp_q.pop_front();
        if ({p, (p ? bus.p1_readdata : bus.p0_readdata)} !== e) begin
          errors++;
          $display("FAIL rd_return: got port %0d data %h, required port %0d data %h",
                   p, (p ? bus.p1_readdata : bus.p0_readdata), e[128], e[127:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_port(input int p, input logic rd, input logic wr, input logic [14:0] a,
                          input logic [15:0] be, input logic [127:0] wd);
    if (p == 0) begin
      bus.p0_read = rd; bus.p0_write = wr; bus.p0_address = a;
      bus.p0_byteenable = be; bus.p0_writedata = wd;
    end else begin
      bus.p1_read = rd; bus.p1_write = wr; bus.p1_address = a;
      bus.p1_byteenable = be; bus.p1_writedata = wd;
    end
  endtask

  task automatic idle_port(input int p);
    set_port(p, 1'b0, 1'b0, 15'd0, 16'd0, 128'd0);
  endtask

  function automatic logic get_wait(input int p);
    return (p == 0) ? bus.p0_waitrequest : bus.p1_waitrequest;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the access.
  task automatic issue(input int p, input logic wr, input logic [14:0] a, input logic [15:0] be,
                       input logic [127:0] wd, output int waited);
    bit   ok;
    logic pb;
    ok = 1'b0;
    pb = (p != 0);
    waited = 0;
    set_port(p, ~wr, wr, a, be, wd);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!get_wait(p)) begin
        ok = 1'b1;
        break;
      end
      waited++;
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: port %0d waitrequest still 1 after 50 cycles, required 0", p);
    end else begin
      if (wr) begin
        for (int i = 0; i < 16; i++) if (be[i]) ref_m[a][8*i +: 8] = wd[8*i +: 8];
      end else begin
        exp_q.push_back({pb, ref_m[a]});
      end
      if (log_en) gnt_log.push_back(p);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_port(0);
    idle_port(1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_empty(input string name);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d reads outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_grants(input string name, input int exp_seq[$]);
    checks++;
    if (gnt_log.size() != exp_seq.size()) begin
      errors++;
      $display("FAIL %s_count: %0d grants, required %0d", name, gnt_log.size(), exp_seq.size());
    end else begin
      for (int k = 0; k < exp_seq.size(); k++) begin
        checks++;
        if (gnt_log[k] !== exp_seq[k]) begin
          errors++;
          $display("FAIL %s_order[%0d]: port %0d, required %0d", name, k, gnt_log[k], exp_seq[k]);
        end
      end
    end
    gnt_log.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_port(0, 1'b1, 1'b0, 15'h0001, 16'hFFFF, 128'd0);
    set_port(1, 1'b1, 1'b0, 15'h0002, 16'hFFFF, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.p0_waitrequest, bus.p1_waitrequest} !== 2'b11) begin
      errors++;
      $display("FAIL reset_wait: %b, required 11", {bus.p0_waitrequest, bus.p1_waitrequest});
    end
    checks++;
    if ({bus.mem_chipselect, bus.mem_write, bus.mem_clken} !== 3'b001) begin
      errors++;
      $display("FAIL reset_mem: cs/wr/clken %b, required 001",
               {bus.mem_chipselect, bus.mem_write, bus.mem_clken});
    end
    checks++;
    if ({bus.p0_readdatavalid, bus.p1_readdatavalid, dbg_state} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: rdv/state %b, required 0000",
               {bus.p0_readdatavalid, bus.p1_readdatavalid, dbg_state});
    end
    do_reset();
  endtask

  task automatic test_write_read();
    int w;
    issue(0, 1'b1, 15'h0010, 16'hFFFF, {16{8'hA5}}, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL wr_wait: waited %0d, required 0", w); end
    issue(0, 1'b0, 15'h0010, 16'hFFFF, 128'd0, w);
    idle_port(0);
    checks++;
    if (w != 0) begin errors++; $display("FAIL rd_wait: waited %0d, required 0", w); end
    @(negedge clk);
    checks++;
    if ({bus.p0_readdatavalid, bus.p1_readdatavalid} !== 2'b10 || bus.p0_readdata !== {16{8'hA5}}) begin
      errors++;
      $display("FAIL wr_rd_return: rdv %b data %h, required 10 and a5..a5",
               {bus.p0_readdatavalid, bus.p1_readdatavalid}, bus.p0_readdata);
    end
    @(negedge clk);
    checks++;
    if ({bus.p0_readdatavalid, bus.p1_readdatavalid} !== 2'b00) begin
      errors++;
      $display("FAIL wr_rd_pulse: rdv %b one cycle later, required 00",
               {bus.p0_readdatavalid, bus.p1_readdatavalid});
    end
    @(posedge clk); #1;
    check_empty("wr_rd");
  endtask

  task automatic test_round_robin();
    int w;
    int exp_seq[$];
    for (int i = 0; i < 12; i++) begin
      issue(1, 1'b1, 15'(16'h0100 + i), 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, w);
      issue(1, 1'b1, 15'(16'h0200 + i), 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, w);
    end
    do_reset();
    log_en = 1'b1;
    fork
      begin
        int w0;
        for (int i = 0; i < 12; i++) issue(0, 1'b0, 15'(16'h0100 + i), 16'hFFFF, 128'd0, w0);
        idle_port(0);
      end
      begin
        int w1;
        for (int i = 0; i < 12; i++) issue(1, 1'b0, 15'(16'h0200 + i), 16'hFFFF, 128'd0, w1);
        idle_port(1);
      end
    join
    log_en = 1'b0;
    for (int k = 0; k < 24; k++) exp_seq.push_back((k / 4) % 2);
    check_grants("rr", exp_seq);
    check_empty("rr");
  endtask

  task automatic test_byteenable();
    int w;
    issue(1, 1'b1, 15'h0033, 16'hFFFF, {16{8'hFF}}, w);
    issue(0, 1'b1, 15'h0033, 16'h0001, {16{8'h5A}}, w);
    idle_port(0);
    issue(1, 1'b0, 15'h0033, 16'hFFFF, 128'd0, w);
    idle_port(1);
    @(negedge clk);
    checks++;
    if (!bus.p1_readdatavalid || bus.p1_readdata !== {{15{8'hFF}}, 8'h5A}) begin
      errors++;
      $display("FAIL be_merge: rdv %b data %h, required 1 and ff..ff5a",
               bus.p1_readdatavalid, bus.p1_readdata);
    end
    @(posedge clk); #1;
    check_empty("be");
  endtask

  task automatic test_single_stream();
    int w;
    int total;
    int exp_seq[$];
    for (int i = 0; i < 100; i++)
      issue(1, 1'b1, 15'(16'h0400 + i), 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, w);
    idle_port(1);
    total = 0;
    for (int i = 0; i < 100; i++) begin
      issue(0, 1'b0, 15'(16'h0400 + i), 16'hFFFF, 128'd0, w);
      total += w;
    end
    checks++;
    if (total != 0) begin errors++; $display("FAIL stream_wait: %0d stall cycles, required 0", total); end
    checks++;
    if (dbg_state !== 2'd1) begin errors++; $display("FAIL stream_state: %0d, required 1", dbg_state); end
    // Port 0 has held ownership well past the limit, so a newcomer wins at once.
    log_en = 1'b1;
    fork
      begin int w0; issue(0, 1'b0, 15'h0400, 16'hFFFF, 128'd0, w0); idle_port(0); end
      begin int w1; issue(1, 1'b0, 15'h0401, 16'hFFFF, 128'd0, w1); idle_port(1); end
    join
    log_en = 1'b0;
    exp_seq = '{1, 0};
    check_grants("sat", exp_seq);
    check_empty("stream");
  endtask

  task automatic test_reset_midread();
    int w;
    int exp_seq[$];
    issue(0, 1'b0, 15'h0010, 16'hFFFF, 128'd0, w);
    idle_port(0);
    reset = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if ({bus.p0_readdatavalid, bus.p1_readdatavalid} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_rdv: %b right after reset, required 00",
               {bus.p0_readdatavalid, bus.p1_readdatavalid});
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.p0_readdatavalid, bus.p1_readdatavalid} !== 2'b00) begin
        errors++;
        $display("FAIL reset_drop_rdv: %b, required 00", {bus.p0_readdatavalid, bus.p1_readdatavalid});
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    log_en = 1'b1;
    fork
      begin int w0; issue(0, 1'b0, 15'h0100, 16'hFFFF, 128'd0, w0); idle_port(0); end
      begin int w1; issue(1, 1'b0, 15'h0200, 16'hFFFF, 128'd0, w1); idle_port(1); end
    join
    log_en = 1'b0;
    exp_seq = '{0, 1};
    check_grants("post_reset", exp_seq);
    check_empty("post_reset");
  endtask

  initial begin
    reset = 1'b1;
    idle_port(0);
    idle_port(1);
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_byteenable();
    test_single_stream();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
